spi_dac_rx: RTL and testbench

SPI_DAC_RX -- requirements
Module: spi_dac_rx

---
 rtl/spi_dac_pkg.sv | 33 +++
 rtl/spi_dac_rx_if.sv | 26 ++
 rtl/spi_dac_rx_sync_edge.sv | 41 ++++
 rtl/spi_dac_rx.sv | 127 ++++++++++++
 tb/tb_spi_dac_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_dac_pkg.sv
// Shared constants, frame field positions and FSM encoding for the SPI DAC receiver.
// The DAC word is 16 bits, MSB first: channel, BUF, GA, SHDN, 10 data bits, 2 don't-care bits.
package spi_dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 10;

  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  // The counter saturates one past a full frame, so over-long frames stay distinguishable.
  localparam int                CNT_W        = 5;
  localparam logic [CNT_W-1:0] BIT_CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] BIT_CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  typedef struct packed {
    logic                 buf_en;
    logic                 gain_1x;
    logic                 shdn_n;
    logic [DATA_BITS-1:0] data;
  } dac_cfg_t;

endpackage

// File: rtl/spi_dac_rx_if.sv
// Pin bundle between an SPI DAC master and the receiver: serial inputs plus decoded outputs.
interface spi_dac_rx_if;
  import spi_dac_pkg::*;

  logic                 dac_sck;
  logic                 dac_sdi;
  logic                 dac_cs;
  logic                 dac_ld;
  logic [DATA_BITS-1:0] data_out;
  logic                 buf_en;
  logic                 gain_1x;
  logic                 shdn_n;
  logic                 data_valid;
  logic                 frame_err;

  modport master (
    output dac_sck, dac_sdi, dac_cs, dac_ld,
    input  data_out, buf_en, gain_1x, shdn_n, data_valid, frame_err
  );

  modport slave (
    input  dac_sck, dac_sdi, dac_cs, dac_ld,
    output data_out, buf_en, gain_1x, shdn_n, data_valid, frame_err
  );

endinterface

// File: rtl/spi_dac_rx_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, with single-cycle rise/fall pulses.
// RESET_VAL is the pin's idle level so that leaving reset never looks like an edge.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: non-blocking assignments let all three stages sample their old inputs on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI DAC slave receiver: frames 16-bit channel-A words into a holding register and
// transfers them to the outputs on a dac_ld strobe.
module spi_dac_rx
  import spi_dac_pkg::*;
(
  input  logic        sysclk,
  input  logic        reset,
  spi_dac_rx_if.slave bus
);

  logic sck_sync, sck_rise, sck_fall;
  logic sdi_sync, sdi_rise, sdi_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic ld_sync, ld_rise, ld_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(sysclk), .reset(reset), .din(bus.dac_sck),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.RESET_VAL(1'b0)) u_sync_sdi (
    .clk(sysclk), .reset(reset), .din(bus.dac_sdi),
    .sync(sdi_sync), .rise(sdi_rise), .fall(sdi_fall)
  );
  sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(sysclk), .reset(reset), .din(bus.dac_cs),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.RESET_VAL(1'b1)) u_sync_ld (
    .clk(sysclk), .reset(reset), .din(bus.dac_ld),
    .sync(ld_sync), .rise(ld_rise), .fall(ld_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_sync, sck_fall, sdi_rise, sdi_fall, ld_sync, ld_rise};

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  dac_cfg_t              hold_q, hold_d;
  logic                  pending_q, pending_d;
  dac_cfg_t              out_q, out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q, frame_err_d;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch below can leave one unassigned (no latch).
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    pending_d    = pending_q;
    out_d        = out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // A load consumes the holding register as it stood before any CHECK in this same cycle.
    if (ld_fall && pending_q) begin
      out_d        = hold_q;
      data_valid_d = 1'b1;
      pending_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (sck_rise && !cs_sync) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_sync};
          if (bit_cnt_q != BIT_CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (cs_rise) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt_q == BIT_CNT_FULL && !shift_q[CH_BIT]) begin
          hold_d = '{buf_en:  shift_q[BUF_BIT],
                     gain_1x: shift_q[GA_BIT],
                     shdn_n:  shift_q[SHDN_BIT],
                     data:    shift_q[DATA_MSB:DATA_LSB]};
          pending_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      pending_q    <= 1'b0;
      out_q        <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      out_q        <= out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = out_q.data;
  assign bus.buf_en     = out_q.buf_en;
  assign bus.gain_1x    = out_q.gain_1x;
  assign bus.shdn_n     = out_q.shdn_n;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed and randomized frames against a word-level model of the DAC receiver:
// a frame is a list of bits, acceptance is a rule on its length and first bit.
module tb_spi_dac_rx;

  localparam int SLOW = 25;  // 1 MHz SCK half period in 50 MHz sysclk cycles

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  spi_dac_rx_if bus ();

  spi_dac_rx dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  int   valid_seen = 0;
  int   err_seen   = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  logic [15:0] m_hold;
  logic        m_pending;
  logic [9:0]  m_data;
  logic        m_buf, m_ga, m_shdn;
  int          m_loads = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge sysclk) begin
    if (bus.data_valid === 1'b1) valid_seen++;
    if (bus.frame_err === 1'b1) err_seen++;
    check("pulse_width", 32'((bus.data_valid && prev_valid) || (bus.frame_err && prev_err)), 32'd0);
    prev_valid = bus.data_valid;
    prev_err   = bus.frame_err;
  end

  function automatic logic frame_ok(input logic [15:0] w, input int nbits);
    return (nbits == 16) && (w[15] == 1'b0);
  endfunction

  task automatic model_reset();
    m_hold    = '0;
    m_pending = 1'b0;
    m_data    = '0;
    m_buf     = 1'b0;
    m_ga      = 1'b0;
    m_shdn    = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"}, bus.data_out, m_data);
    check({tag, "_buf"},  bus.buf_en,   m_buf);
    check({tag, "_ga"},   bus.gain_1x,  m_ga);
    check({tag, "_shdn"}, bus.shdn_n,   m_shdn);
  endtask

  task automatic sck_pulse(input logic b, input int half);
    bus.dac_sdi = b;
    repeat (half) @(negedge sysclk);
    bus.dac_sck = 1'b1;
    repeat (half) @(negedge sysclk);
    bus.dac_sck = 1'b0;
  endtask

  // dac_ld was driven low on the negedge just before this call; its first sampling edge is E1.
  task automatic load_checks(input string tag, input logic had);
    @(negedge sysclk);
    check({tag, "_v1"}, bus.data_valid, 1'b0);
    @(negedge sysclk);
    check({tag, "_v2"}, bus.data_valid, 1'b0);
    @(negedge sysclk);
    check({tag, "_v3"}, bus.data_valid, had);
    if (had) begin
      m_data    = 10'((m_hold >> 2) & 16'h03FF);
      m_buf     = m_hold[14];
      m_ga      = m_hold[13];
      m_shdn    = m_hold[12];
      m_pending = 1'b0;
      m_loads++;
    end
    check_outputs(tag);
    @(negedge sysclk);
    check({tag, "_v4"}, bus.data_valid, 1'b0);
  endtask

  task automatic do_load(input string tag);
    logic had;
    had = m_pending;
    @(negedge sysclk);
    bus.dac_ld = 1'b0;
    load_checks(tag, had);
    bus.dac_ld = 1'b1;
    repeat (6) @(negedge sysclk);
  endtask

  // with_load drops dac_ld one cycle after dac_cs rises, landing the load on the CHECK cycle.
  task automatic run_frame(input string tag, input logic [15:0] w, input int nbits,
                           input int half, input logic with_load);
    int   e0;
    logic ok;
    logic had;
    e0  = err_seen;
    ok  = frame_ok(w, nbits);
    had = m_pending;
    @(negedge sysclk);
    bus.dac_cs = 1'b0;
    repeat (half) @(negedge sysclk);
    for (int i = 0; i < nbits; i++) begin
      sck_pulse((i < 16) ? w[15-i] : 1'b0, half);
    end
    repeat (half) @(negedge sysclk);
    bus.dac_cs = 1'b1;
    if (with_load) begin
      @(negedge sysclk);
      bus.dac_ld = 1'b0;
      load_checks({tag, "_ld"}, had);
      bus.dac_ld = 1'b1;
    end
    repeat (8) @(negedge sysclk);
    check({tag, "_err"}, 32'(err_seen - e0), ok ? 32'd0 : 32'd1);
    if (ok) begin
      m_hold    = w;
      m_pending = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] aborted;
    aborted     = 16'h3AAC;
    bus.dac_sck = 1'b0;
    bus.dac_sdi = 1'b0;
    bus.dac_cs  = 1'b1;
    bus.dac_ld  = 1'b1;
    reset       = 1'b1;
    model_reset();

    repeat (4) @(negedge sysclk);
    check_outputs("rst");
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_err",   bus.frame_err,  1'b0);
    reset = 1'b0;
    repeat (6) @(negedge sysclk);
    check("rst_no_spurious", 32'(valid_seen + err_seen), 32'd0);

    // Wrong-length frames are rejected and leave nothing to load.
    run_frame("short15", 16'h3AAC, 15, SLOW, 1'b0);
    do_load("short15_ld");
    run_frame("long17", 16'h3AAC, 17, SLOW, 1'b0);
    do_load("long17_ld");
    check("bad_len_data", bus.data_out, 10'h000);

    run_frame("chan_b", 16'hB000, 16, SLOW, 1'b0);
    do_load("chan_b_ld");

    run_frame("f3aac", 16'h3AAC, 16, SLOW, 1'b0);
    do_load("f3aac_ld");
    check("f3aac_data_k", bus.data_out, 10'h2AB);
    check("f3aac_ga_k",   bus.gain_1x,  1'b1);
    check("f3aac_shdn_k", bus.shdn_n,   1'b1);
    check("f3aac_buf_k",  bus.buf_en,   1'b0);

    // Back-to-back frames: only the latest is loaded, and only once.
    run_frame("b2b_a", 16'h3004, 16, SLOW, 1'b0);
    run_frame("b2b_b", 16'h3FFC, 16, SLOW, 1'b0);
    do_load("b2b_ld");
    check("b2b_data_k", bus.data_out, 10'h3FF);
    do_load("b2b_again");

    // Load on the CHECK cycle takes the older word; the new one stays pending.
    run_frame("ovl_a", 16'h3004, 16, SLOW, 1'b0);
    run_frame("ovl_b", 16'h3FFC, 16, SLOW, 1'b1);
    check("ovl_first_k", bus.data_out, 10'h001);
    do_load("ovl_second");
    check("ovl_second_k", bus.data_out, 10'h3FF);

    // Reset in the middle of a frame.
    @(negedge sysclk);
    bus.dac_cs = 1'b0;
    repeat (SLOW) @(negedge sysclk);
    for (int i = 0; i < 8; i++) sck_pulse(aborted[15-i], SLOW);
    reset      = 1'b1;
    bus.dac_cs = 1'b1;
    repeat (5) @(negedge sysclk);
    model_reset();
    check_outputs("mid_rst");
    reset = 1'b0;
    repeat (6) @(negedge sysclk);
    run_frame("after_rst", 16'h3008, 16, SLOW, 1'b0);
    do_load("after_rst_ld");
    check("after_rst_k", bus.data_out, 10'h002);

    // SCK activity with chip select idle must not reach the shift register.
    for (int i = 0; i < 12; i++) sck_pulse(1'($urandom), SLOW);
    run_frame("cs_hi", 16'h3000, 16, SLOW, 1'b0);
    do_load("cs_hi_ld");
    check("cs_hi_k", bus.data_out, 10'h000);

    for (int k = 0; k < 12; k++) begin
      logic [15:0] rw;
      int          sel;
      int          nb;
      rw  = 16'($urandom);
      sel = int'($urandom_range(0, 5));
      nb  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      run_frame($sformatf("rnd%0d", k), rw, nb, int'($urandom_range(3, 8)),
                $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_load($sformatf("rnd%0d_ld", k));
    end

    check("valid_total", 32'(valid_seen), 32'(m_loads));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
